// File: rtl/unary_multiply_two_pkg.sv
// unary_pkg: shared state type, counter sizing and tie-break polarity for the unary arithmetic units
package unary_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic TIE_EMITS_ONE = 1'b1;
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/unary_multiply_two_if.sv
// unary_multiply_two_if: unary input stream plus unary output stream with completion flag
interface unary_multiply_two_if;
  logic a;
  logic ready;
  logic valid;
  logic y;
  logic done;
  modport master(output a, ready, input valid, y, done);
  modport slave(input a, ready, output valid, y, done);
endinterface

// File: rtl/unary_multiply_two_bounds_decider.sv
// unary_bounds_decider: picks the next output bit that keeps the output ones count between the running bounds of the target
module unary_bounds_decider
  import unary_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = count_width(N),
  parameter int KW = CW + 2
) (
  input  logic [CW-1:0] a_ones,
  input  logic [CW-1:0] a_count,
  input  logic [CW-1:0] y_ones,
  input  logic [CW-1:0] y_count,
  output logic          emit_bit
);
  logic [KW-1:0] n_k, lo_raw, hi_raw, lo, hi, l2, h2, m2, dl, du;
  assign n_k      = KW'(N);
  assign lo_raw   = KW'(a_ones) << 1;
  assign hi_raw   = (KW'(a_ones) + n_k - KW'(a_count)) << 1;
  assign lo       = lo_raw < n_k ? lo_raw : n_k;
  assign hi       = hi_raw < n_k ? hi_raw : n_k;
  assign l2       = lo << 1;
  assign h2       = hi << 1;
  assign m2       = (KW'(y_ones) << 1) + n_k - KW'(y_count);
  assign dl       = m2 - l2;
  assign du       = h2 - m2;
  assign emit_bit = m2 <= l2 ? 1'b1 :
                    m2 >= h2 ? 1'b0 :
                    dl < du  ? 1'b1 :
                    dl == du ? TIE_EMITS_ONE : 1'b0;
endmodule

// File: rtl/unary_multiply_two.sv
// unary_multiply_two: streaming unary multiply-by-two saturating at 1.0, decided online from target bounds
module unary_multiply_two
  import unary_pkg::*;
#(
  parameter int INPUT_WIDTH = 32,
  parameter int COUNT_WIDTH = count_width(INPUT_WIDTH),
  parameter int CALC_WIDTH  = COUNT_WIDTH + 2
) (
  input logic                 clk,
  input logic                 reset,
  unary_multiply_two_if.slave u
);
  localparam logic [COUNT_WIDTH-1:0] N_C = COUNT_WIDTH'(INPUT_WIDTH);
  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] a_ones_q, a_ones_d, a_count_q, a_count_d;
  logic [COUNT_WIDTH-1:0] y_ones_q, y_ones_d, y_count_q, y_count_d;
  logic                   y_q, y_d, valid_q, valid_d, done_q, done_d;
  logic                   accept, decide, finish, emit;
  unary_bounds_decider #(
    .N (INPUT_WIDTH),
    .CW(COUNT_WIDTH),
    .KW(CALC_WIDTH)
  ) u_decider (
    .a_ones  (a_ones_q),
    .a_count (a_count_q),
    .y_ones  (y_ones_q),
    .y_count (y_count_q),
    .emit_bit(emit)
  );
  // accept input bits, emit one decided bit per cycle once input has started, and close the stream after N outputs
  always_comb begin
    accept    = u.ready && state_q != DONE && a_count_q < N_C;
    decide    = state_q != DONE && a_count_q != '0 && y_count_q < N_C;
    finish    = state_q != DONE && y_count_q == N_C;
    a_ones_d  = a_ones_q + COUNT_WIDTH'(accept && u.a);
    a_count_d = a_count_q + COUNT_WIDTH'(accept);
    y_ones_d  = y_ones_q + COUNT_WIDTH'(decide && emit);
    y_count_d = y_count_q + COUNT_WIDTH'(decide);
    y_d       = decide && emit;
    valid_d   = decide;
    done_d    = done_q || finish;
    state_d   = finish ? DONE : (state_q == IDLE && accept) ? RUN : state_q;
  end
  // state and counters; active-low reset discards any stream in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      a_ones_q  <= '0;
      a_count_q <= '0;
      y_ones_q  <= '0;
      y_count_q <= '0;
      y_q       <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_ones_q  <= a_ones_d;
      a_count_q <= a_count_d;
      y_ones_q  <= y_ones_d;
      y_count_q <= y_count_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end
  assign u.y     = y_q;
  assign u.valid = valid_q;
  assign u.done  = done_q;
endmodule

// File: doc/unary_multiply_two.md
Name: unary_multiply_two

Overview:
- Streaming unary (bitstream) multiply-by-two with saturation at 1.0. It is the inverse counterpart of the divide-by-two unary unit.
- Consumes an INPUT_WIDTH-bit unary stream `a` (one bit per `ready`-qualified cycle) and emits an INPUT_WIDTH-bit stream `y` whose ones count approximates min(2·A, N), where A is the input ones count and N = INPUT_WIDTH.
- Decisions are made online from running bounds on the final target, so output starts one cycle after the first accepted input bit.
- Sits in the unary arithmetic chain between stream producers and divide/scale units.

Parameters:
- INPUT_WIDTH, 32: stream length N in bits, for both input and output.
- COUNT_WIDTH, $clog2(INPUT_WIDTH+1): width of the bit/ones counters.
- CALC_WIDTH, COUNT_WIDTH+2: width of the internal ×2-scaled bound arithmetic. It must hold 2N without overflow.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- a  input  1  input unary bit; sampled only when ready=1.
- ready  input  1  input qualifier; a is accepted on an edge where ready=1 and state≠DONE and a_count<N.
- valid  output  1  y carries an output bit this cycle.
- y  output  1  output unary bit.
- done  output  1  high once all N output bits have been emitted; held until reset.

Behaviour:
- Reset (reset=0 at an edge): a_ones, a_count, y_ones, y_count = 0; y=0; valid=0; done=0; state=IDLE. Reset mid-stream discards everything; the next stream starts fresh.
- States:
  - IDLE: a_count==0.
  - RUN: a_count>0 and y_count<N.
  - DONE: entered on the edge where y_count==N is observed; left only by reset.
- Input accept: on an edge with ready=1, a_count<N and state≠DONE, a_ones += a and a_count += 1. Otherwise both counters hold.
- Bounds, combinational from registered counters. All arithmetic is in CALC_WIDTH, unsigned, with no wrap possible:
  - lo = min(2·a_ones, N)
  - hi = min(2·(a_ones + N − a_count), N)
  - L2 = 2·lo; H2 = 2·hi; M2 = 2·y_ones + (N − y_count)
  - dL = M2 − L2, valid only when M2>L2; dU = H2 − M2, valid only when M2<H2.
- Decision, when state≠DONE, a_count>0 (registered value) and y_count<N. Priority order:
  1. M2 ≤ L2 → emit 1.
  2. else M2 ≥ H2 → emit 0.
  3. else dL ≤ dU → emit 1 (a tie emits 1).
  4. else emit 0.
- On emit: y ← bit, valid ← 1, y_count += 1, and y_ones += 1 when the bit is 1.
- Output latency: the first y/valid is registered on the edge after the first accepted input. Output does not stall on ready=0; it keeps one bit per cycle once a_count>0.
- valid is high for exactly N consecutive cycles per stream.
- End of stream: on the edge where y_count==N, y ← 0, valid ← 0, done ← 1, state ← DONE. Further a/ready are ignored.
- If output finishes before all N inputs arrive (ready gaps), the remaining inputs are ignored; the emitted stream stands.
- Simultaneous accept and decide on one edge: the decision uses pre-edge counters, and the accept updates a_* for the next cycle.

Decomposition:
- Shared package unary_pkg holds:
  - typedef enum for the state: IDLE, RUN, DONE.
  - count-width helper function.
  - constants for tie-break polarity (TIE_EMITS_ONE=1).
- Sub-module unary_bounds_decider is combinational:
  - inputs: a_ones, a_count, y_ones, y_count.
  - output: emit_bit.
  - It computes lo/hi/M2 and the priority decision. It is reused later by the unary scale-by-K variants.

Test Plan:
- N=8, ready held 1, a=all ones → y=1,1,1,1,1,1,1,1 on the 8 cycles after first accept; valid 8 cycles; done rises on the 10th edge.
- N=8, ready held 1, a=all zeros → y=1,0,1,0,0,0,0,0 (tie-break then bound convergence); y ones count 2.
- N=8, ready=0 for 3 cycles after 2 accepted ones → valid stays continuous; output matches a bit-accurate model of the bound/decision rules.
- Random a and ready over 1000 streams, N=32 → every stream matches the model bit-for-bit. Final ones count is within the model-reported error of min(2A, 32).
- Assert reset=0 mid-stream (after 5 outputs) → next edge all outputs 0, state IDLE. A new stream then behaves identically to a fresh-from-reset stream.
- After done=1, drive ready=1 with a=1 for 10 cycles → no counter changes; valid=0, y=0, done stays 1.
